// File: rtl/load_store_unit.sv
// Load/store unit between a core and a word-wide synchronous memory.
// Handles byte/halfword/word accesses, big-endian lanes, sub-word stores by read-modify-write.
module load_store_unit #(
  parameter int unsigned WA_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Req,
  input  logic            Wr,
  input  logic [1:0]      Size,
  input  logic            Unsigned,
  input  logic [WA_W+1:0] Addr,
  input  logic [31:0]     WData,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic [31:0]     RData,
  output logic [WA_W-1:0] MemAddr,
  output logic [31:0]     MemWData,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [31:0]     MemRData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state, stateNext;
  logic            wrQ, unsQ, errQ;
  logic [1:0]      sizeQ;
  logic [WA_W+1:0] addrQ;
  logic [31:0]     wordQ;
  logic [31:0]     rDataQ;
  logic            misalignedC;

  // Extract the addressed lane and extend it to 32 bits
  function automatic logic [31:0] loadExtend(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store data onto the addressed lane of the captured word
  function automatic logic [31:0] storeMerge(input logic [31:0] word, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    res[31:24] = wd[7:0];
          2'd1:    res[23:16] = wd[7:0];
          2'd2:    res[15:8]  = wd[7:0];
          default: res[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) res[15:0]  = wd[15:0];
        else        res[31:16] = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  always_comb begin
    misalignedC = 1'b0;
    case (Size)
      2'b01:   misalignedC = Addr[0];
      2'b10:   misalignedC = (Addr[1:0] != 2'b00);
      2'b11:   misalignedC = 1'b1;
      default: misalignedC = 1'b0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (misalignedC)                stateNext = DONE;
          else if (Wr && (Size == 2'b10)) stateNext = WRITE;
          else                            stateNext = READ;
        end
      end
      READ:    stateNext = wrQ ? WRITE : DONE;
      WRITE:   stateNext = DONE;
      default: stateNext = IDLE;
    endcase
  end

  // wordQ holds the store data from acceptance, then the merged word after READ
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wrQ    <= 1'b0;
      unsQ   <= 1'b0;
      errQ   <= 1'b0;
      sizeQ  <= 2'b00;
      addrQ  <= '0;
      wordQ  <= '0;
      rDataQ <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && Req) begin
        wrQ   <= Wr;
        sizeQ <= Size;
        unsQ  <= Unsigned;
        addrQ <= Addr;
        wordQ <= WData;
        errQ  <= misalignedC;
      end
      if (state == READ) begin
        if (wrQ) wordQ  <= storeMerge(MemRData, wordQ, sizeQ, addrQ[1:0]);
        else     rDataQ <= loadExtend(MemRData, sizeQ, addrQ[1:0], unsQ);
      end
    end
  end

  assign Busy     = (state != IDLE);
  assign Done     = (state == DONE);
  assign Err      = (state == DONE) && errQ;
  assign RData    = rDataQ;
  assign MemAddr  = addrQ[WA_W+1:2];
  assign MemRead  = (state == READ);
  assign MemWrite = (state == WRITE) && !reset;
  assign MemWData = (state == WRITE) ? wordQ : 32'd0;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WA_W, default 7, giving the memory word-address width (128 words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Req, input, 1 bit: access request, sampled only in IDLE.
REQ-005 SHALL have port Wr, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port Size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port Unsigned, input, 1 bit: 1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-008 SHALL have port Addr, input, WA_W+2 bits: byte address.
REQ-009 SHALL have port WData, input, 32 bits: store data, right-justified.
REQ-010 SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port Err, output, 1 bit: misalignment flag, valid with Done.
REQ-013 SHALL have port RData, output, 32 bits: extended load result, held until the next Done.
REQ-014 SHALL have port MemAddr, output, WA_W bits: word address, equal to latched Addr[WA_W+1:2].
REQ-015 SHALL have port MemWData, output, 32 bits: word to store.
REQ-016 SHALL have ports MemRead and MemWrite, output, 1 bit each: memory strobes.
REQ-017 SHALL have port MemRData, input, 32 bits: combinational memory read data.

Function
REQ-018 SHALL implement an FSM with states IDLE, READ, WRITE and DONE.
REQ-019 SHALL, in IDLE with Req=1, latch Wr, Size, Unsigned, Addr and WData; Req SHALL be ignored in every other state.
REQ-020 SHALL treat as misaligned: Size=01 with Addr[0]=1; Size=10 with Addr[1:0]!=0; Size=11.
REQ-021 SHALL, for a misaligned request, go IDLE->DONE with Err=1, assert no memory strobe, and leave RData unchanged.
REQ-022 SHALL sequence a load as IDLE->READ->DONE: MemRead=1 in READ, RData registered at the READ->DONE edge, Done in the second cycle after acceptance.
REQ-023 SHALL sequence a word store as IDLE->WRITE->DONE: MemWrite=1 and MemWData=WData in WRITE.
REQ-024 SHALL sequence a byte or halfword store as read-modify-write, IDLE->READ->WRITE->DONE: word captured in READ, merged word driven in WRITE, Done in the third cycle after acceptance.
REQ-025 SHALL use big-endian lane order: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-026 SHALL, on a sub-word store, replace only the addressed lane with WData[7:0] or WData[15:0]; other lanes SHALL keep the captured value.
REQ-027 SHALL extend sub-word loads to 32 bits per Unsigned; word loads SHALL pass unchanged.
REQ-028 SHALL return DONE->IDLE unconditionally; Done and Err SHALL be high only in DONE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-029 SHALL drive MemRead high only in READ and MemWrite high only in WRITE, and never both at once.
REQ-030 SHALL drive MemWData to 0 outside WRITE.

Reset
REQ-031 SHALL, with reset=1 at a rising edge, enter IDLE and clear RData, Done, Err and all latched request fields to 0.
REQ-032 SHALL gate MemWrite with !reset, so a reset asserted during WRITE suppresses that memory write.
REQ-033 SHALL abort an in-flight access on reset with no Done pulse; reset SHALL have priority over Req.

Verification
REQ-034 SHALL verify a word load: memory word 13 = 0x00000003; load, Size=10, Addr=0x034 -> Done two cycles after acceptance, RData=0x00000003, Err=0, one MemRead cycle.
REQ-035 SHALL verify a signed byte load: word 5 = 0x12F45678; load, Size=00, Unsigned=0, Addr=0x015 -> RData=0xFFFFFFF4; repeated with Unsigned=1 -> RData=0x000000F4.
REQ-036 SHALL verify a halfword store by read-modify-write: word 2 = 0xAABBCCDD; store, Size=01, Addr=0x00A, WData=0x00001234 -> MemRead cycle, then MemWrite cycle with MemWData=0xAABB1234, Done in the third cycle.
REQ-037 SHALL verify a misaligned access: word load at Addr=0x006 -> Done and Err=1 one cycle after acceptance, no MemRead/MemWrite pulse, RData unchanged.
REQ-038 SHALL verify reset during WRITE: reset=1 in the WRITE cycle of a word store -> MemWrite=0, target word unchanged, no Done, state IDLE, all outputs 0.
REQ-039 SHALL verify Req held high throughout a load: exactly one access, new request accepted only in the IDLE cycle after Done.
